vmem_fill_ctrl: RTL and testbench
=================================

Name: vmem_fill_ctrl

Overview:
Memory-mapped rectangle-fill engine and write-port arbiter for the 3-bit-per-pixel video memory. The CPU programs origin, size and colour, then starts the fill. The engine then writes one pixel per cycle into vmem at address {y,x}. It shares the single vmem write port with direct CPU pixel stores, and the CPU always has priority. It sits between the dbus decode (vmem/cfg selects) and the vmem write port. The display read path is untouched.

Parameters:
MAX_COORD, 239, largest valid x/y; pixels beyond it are clipped (no write, cycle still consumed).
COLOR_W, 3, pixel width written to vmem.
CFG_AW, 2, config word-index width (4 registers).

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
cfg_we_i  input  1  config register write strobe
cfg_addr_i  input  CFG_AW  register index: 0 CTRL, 1 ORIGIN, 2 SIZE, 3 COLOR
cfg_wdata_i  input  32  config write data
cfg_rdata_o  output  32  config read data, registered
cpu_we_i  input  1  direct CPU pixel write
cpu_addr_i  input  16  direct write address {y,x}
cpu_wdata_i  input  COLOR_W  direct write pixel
vmem_we_o  output  1  vmem write enable, registered
vmem_addr_o  output  16  vmem write address {y,x}, registered
vmem_wdata_o  output  COLOR_W  vmem write pixel, registered
busy_o  output  1  engine in FILL state
done_o  output  1  one-cycle pulse when a fill completes (not on abort)

Behaviour:
- Reset (async assert, sync release): the following are 0.
  - All outputs, including vmem_we_o, busy_o, done_o and cfg_rdata_o.
  - Registers: x0, y0, wm1, hm1, color.
  - The sticky done flag. The FSM is in IDLE.
- Registers:
  - ORIGIN: x0 = [7:0], y0 = [15:8].
  - SIZE: wm1 = [7:0], hm1 = [15:8]. Width = wm1+1 and height = hm1+1, range 1..256.
  - COLOR: [COLOR_W-1:0].
  - CTRL write: bit0 start, bit1 clear done flag, bit2 abort.
  - CTRL read: bit0 busy, bit1 sticky done. All other read bits are 0.
- Reads: cfg_rdata_o <= reg[cfg_addr_i] every cycle that cfg_we_i is 0, giving one-cycle latency (same as the data RAM). The value holds during writes.
- Writes to ORIGIN, SIZE or COLOR while busy are ignored. Registers keep their values across fills.
- FSM:
  - IDLE -> FILL on start=1 with abort=0. This loads cx=x0, cy=y0, col=0, row=0 and clears the sticky done flag.
  - Start while busy is ignored.
  - FILL, per cycle, when cpu_we_i=0 (grant):
    - Issue a write at addr {cy,cx} with color. vmem_we_o=1 only if cx<=MAX_COORD and cy<=MAX_COORD; otherwise it is suppressed.
    - Then advance: if col==wm1, set col=0, cx=x0, row++, cy++; else col++, cx++.
    - cx and cy are 9 bits, so x0+w never wraps into a small coordinate.
  - Last pixel: a grant with col==wm1 and row==hm1 goes to DONE.
  - DONE: for one cycle, done_o=1, sticky done=1, busy_o=0. Then IDLE.
  - Abort in FILL: go to IDLE next cycle. No further engine writes, and done is not set. Abort in IDLE has no effect.
  - If start and abort are set in the same write, abort wins and no fill starts.
- Arbitration:
  - When cpu_we_i=1, the CPU write is registered to the vmem_* outputs next cycle.
  - The engine stalls that cycle and holds its position. No pixel is lost or duplicated.
- Latency:
  - A start write at cycle N gives the first engine write on vmem_we_o at N+2 (FSM enters FILL at N+1, output register at N+2).
  - A w*h fill with no CPU contention takes w*h cycles in FILL.
  - busy_o is 1 from N+1 through the last FILL cycle.
- Reset mid-fill: the FSM returns to IDLE immediately and vmem_we_o goes to 0 asynchronously.

Decomposition:
- Shared package/header (config.vh):
  - Register indices CTRL/ORIGIN/SIZE/COLOR.
  - CTRL bit positions START/CLR/ABORT and BUSY/DONE.
  - FSM state encodings IDLE/FILL/DONE.
  - The vmem base address select bit (dbus_addr[28]) and the cfg base address select bit (dbus_addr[29]).
- One natural sub-module: fill_addr_gen. It holds the cx/cy/col/row counters with a load/step interface and outputs the last and in-bounds flags. The FSM, register file and arbiter mux stay in vmem_fill_ctrl.

Test Plan:
1. Basic fill:
   - Stimulus: ORIGIN=0x0A05, SIZE=0x0203 (4x3), COLOR=5, start.
   - Expected: 12 writes, 0x0A05..0x0A08, 0x0B05..0x0B08, 0x0C05..0x0C08, all data 5, on consecutive cycles.
   - Expected: done_o pulses once; a CTRL read returns 0x2.
2. CPU contention:
   - Stimulus: the test 1 fill, plus cpu_we_i=1 at addr 0x0000, data 2, on the 3rd and 4th fill cycles.
   - Expected: the CPU writes appear in order.
   - Expected: the engine sequence still has exactly 12 distinct addresses with no gaps, and completes 2 cycles later.
3. Clipping:
   - Stimulus: ORIGIN=0xEEEE (238,238), SIZE=0x0303.
   - Expected: only 4 writes, at 0xEEEE, 0xEEEF, 0xEFEE, 0xEFEF.
   - Expected: busy lasts 16 FILL cycles; no writes with x or y >= 240.
4. Abort:
   - Stimulus: start a 0xFFFF-size fill, then write CTRL=0x4 after 100 cycles.
   - Expected: writes stop within 1 cycle; busy_o=0; done flag=0; done_o never pulses.
5. Ignored writes:
   - Stimulus: while busy, write COLOR=7 and start again.
   - Expected: the fill completes with the original colour; exactly one done_o pulse.
6. Reset:
   - Stimulus: assert rst_ni=0 mid-fill.
   - Expected: vmem_we_o=0 and busy_o=0 immediately; all register reads return 0 after release.

Source files
------------

// File: rtl/vmem_fill_ctrl_pkg.sv
// Shared constants for the video-memory rectangle-fill engine:
// register map, CTRL bit positions, FSM encodings and dbus select bits.
package vmem_fill_ctrl_pkg;

    localparam int DEF_MAX_COORD = 239;
    localparam int DEF_COLOR_W   = 3;
    localparam int DEF_CFG_AW    = 2;

    localparam logic [DEF_CFG_AW-1:0] REG_CTRL   = 2'd0;
    localparam logic [DEF_CFG_AW-1:0] REG_ORIGIN = 2'd1;
    localparam logic [DEF_CFG_AW-1:0] REG_SIZE   = 2'd2;
    localparam logic [DEF_CFG_AW-1:0] REG_COLOR  = 2'd3;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;
    localparam int CTRL_ABORT = 2;

    // CTRL read bits
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;

    // dbus address bits that select the vmem and cfg windows upstream
    localparam int VMEM_SEL_BIT = 28;
    localparam int CFG_SEL_BIT  = 29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/vmem_fill_ctrl_addr_gen.sv
// Rectangle walk counters: column/row position plus 9-bit pixel coordinates,
// so origin + extent never wraps back into a small, visible coordinate.
module fill_addr_gen #(
    parameter int MAX_COORD = 239
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [7:0]  x0_i,
    input  logic [7:0]  y0_i,
    input  logic [7:0]  wm1_i,
    input  logic [7:0]  hm1_i,
    output logic [15:0] addr_o,
    output logic        last_o,
    output logic        in_bounds_o
);

    logic [8:0] cx;
    logic [8:0] cy;
    logic [7:0] col;
    logic [7:0] row;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cx  <= 9'd0;
            cy  <= 9'd0;
            col <= 8'd0;
            row <= 8'd0;
        end else if (load_i) begin
            cx  <= {1'b0, x0_i};
            cy  <= {1'b0, y0_i};
            col <= 8'd0;
            row <= 8'd0;
        end else if (step_i) begin
            if (col == wm1_i) begin
                col <= 8'd0;
                cx  <= {1'b0, x0_i};
                row <= row + 8'd1;
                cy  <= cy + 9'd1;
            end else begin
                col <= col + 8'd1;
                cx  <= cx + 9'd1;
            end
        end
    end

    assign addr_o      = {cy[7:0], cx[7:0]};
    assign last_o      = (col == wm1_i) && (row == hm1_i);
    assign in_bounds_o = (cx <= 9'(MAX_COORD)) && (cy <= 9'(MAX_COORD));

endmodule

// File: rtl/vmem_fill_ctrl.sv
// Rectangle-fill engine and vmem write-port arbiter. CPU pixel stores always
// win the port; the engine stalls in place while the CPU writes.
module vmem_fill_ctrl
    import vmem_fill_ctrl_pkg::*;
#(
    parameter int MAX_COORD = DEF_MAX_COORD,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int CFG_AW    = DEF_CFG_AW
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_we_i,
    input  logic [CFG_AW-1:0]  cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    input  logic               cpu_we_i,
    input  logic [15:0]        cpu_addr_i,
    input  logic [COLOR_W-1:0] cpu_wdata_i,
    output logic               vmem_we_o,
    output logic [15:0]        vmem_addr_o,
    output logic [COLOR_W-1:0] vmem_wdata_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         dbg_state_o
);

    fill_state_e        state;
    logic [7:0]         x0, y0, wm1, hm1;
    logic [COLOR_W-1:0] color;
    logic               done_flag;

    logic        ctrl_wr, start_req, abort_req, clr_req;
    logic        fill_active, grant, load;
    logic [15:0] eng_addr;
    logic        eng_last, eng_in_bounds;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign ctrl_wr     = cfg_we_i && (cfg_addr_i == REG_CTRL);
    // Abort dominates start when both arrive in one CTRL write.
    assign abort_req   = ctrl_wr && cfg_wdata_i[CTRL_ABORT];
    assign start_req   = ctrl_wr && cfg_wdata_i[CTRL_START] && !cfg_wdata_i[CTRL_ABORT];
    assign clr_req     = ctrl_wr && cfg_wdata_i[CTRL_CLR];
    assign fill_active = (state == ST_FILL);
    assign grant       = fill_active && !cpu_we_i && !abort_req;
    assign load        = (state == ST_IDLE) && start_req;
    assign dbg_state_o = state;
    assign unused_wdata = ^cfg_wdata_i[31:16];

    fill_addr_gen #(
        .MAX_COORD (MAX_COORD)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load),
        .step_i      (grant),
        .x0_i        (x0),
        .y0_i        (y0),
        .wm1_i       (wm1),
        .hm1_i       (hm1),
        .addr_o      (eng_addr),
        .last_o      (eng_last),
        .in_bounds_o (eng_in_bounds)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (clr_req) done_flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state     <= ST_FILL;
                        busy_o    <= 1'b1;
                        done_flag <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (abort_req) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (grant && eng_last) begin
                        state     <= ST_DONE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        done_flag <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Geometry and colour are frozen while a fill is in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x0    <= 8'd0;
            y0    <= 8'd0;
            wm1   <= 8'd0;
            hm1   <= 8'd0;
            color <= '0;
        end else if (cfg_we_i && !fill_active) begin
            case (cfg_addr_i)
                REG_ORIGIN: begin
                    x0 <= cfg_wdata_i[7:0];
                    y0 <= cfg_wdata_i[15:8];
                end
                REG_SIZE: begin
                    wm1 <= cfg_wdata_i[7:0];
                    hm1 <= cfg_wdata_i[15:8];
                end
                REG_COLOR: color <= cfg_wdata_i[COLOR_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (cfg_addr_i)
            REG_CTRL: begin
                rd_mux[STAT_BUSY] = busy_o;
                rd_mux[STAT_DONE] = done_flag;
            end
            REG_ORIGIN: rd_mux = {16'd0, y0, x0};
            REG_SIZE:   rd_mux = {16'd0, hm1, wm1};
            REG_COLOR:  rd_mux = {{(32-COLOR_W){1'b0}}, color};
            default:    rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rdata_o <= 32'd0;
        end else if (!cfg_we_i) begin
            cfg_rdata_o <= rd_mux;
        end
    end

    // Clipped pixels still consume their slot but never assert the write enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vmem_we_o    <= 1'b0;
            vmem_addr_o  <= 16'd0;
            vmem_wdata_o <= '0;
        end else if (cpu_we_i) begin
            vmem_we_o    <= 1'b1;
            vmem_addr_o  <= cpu_addr_i;
            vmem_wdata_o <= cpu_wdata_i;
        end else if (grant) begin
            vmem_we_o    <= eng_in_bounds;
            vmem_addr_o  <= eng_addr;
            vmem_wdata_o <= color;
        end else begin
            vmem_we_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Directed bench for vmem_fill_ctrl: expected vmem writes are queued as
// stimulus is issued and a negedge monitor pops and compares each write.
module tb_vmem_fill_ctrl;
    import vmem_fill_ctrl_pkg::*;

    localparam int W = 16 + DEF_COLOR_W;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_we = 1'b0;
    logic [DEF_CFG_AW-1:0]  cfg_addr = '0;
    logic [31:0]            cfg_wdata = '0;
    logic [31:0]            cfg_rdata_o;
    logic                   cpu_we = 1'b0;
    logic [15:0]            cpu_addr = '0;
    logic [DEF_COLOR_W-1:0] cpu_wdata = '0;
    logic                   vmem_we_o;
    logic [15:0]            vmem_addr_o;
    logic [DEF_COLOR_W-1:0] vmem_wdata_o;
    logic                   busy_o;
    logic                   done_o;
    logic [1:0]             dbg_state_o;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int done_cnt  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_got;
    logic [W-1:0] mon_exp;

    vmem_fill_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rdata_o  (cfg_rdata_o),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .vmem_we_o    (vmem_we_o),
        .vmem_addr_o  (vmem_addr_o),
        .vmem_wdata_o (vmem_wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (vmem_we_o) begin
            mon_got = {vmem_addr_o, vmem_wdata_o};
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got 0x%0h required no write", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("vmem_write", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    // driver tasks
    task automatic cfg_write(input logic [DEF_CFG_AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [DEF_CFG_AW-1:0] a, output logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b0; cfg_addr = a;
        @(negedge clk);
        d = cfg_rdata_o;
    endtask

    task automatic push_px(input logic [15:0] a, input logic [DEF_COLOR_W-1:0] c);
        exp_q.push_back({a, c});
    endtask

    // Pixels first..last-1 of a w-wide rectangle, row-major, clipped at 239.
    task automatic push_rect(input int x0, input int y0, input int w,
                             input int first, input int last, input logic [DEF_COLOR_W-1:0] c);
        for (int i = first; i < last; i++) begin
            int x, y;
            x = x0 + (i % w);
            y = y0 + (i / w);
            if (x <= 239 && y <= 239) push_px({y[7:0], x[7:0]}, c);
        end
    endtask

    // Counts busy negedges until done_o is seen or the budget runs out.
    task automatic wait_done(input int budget, inout int busy_n, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
            if (busy_o) busy_n++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          busy_n;
        int          d0;
        bit          got;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_vmem_we", 32'(vmem_we_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rdata", cfg_rdata_o, 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            cfg_read(2'(r), rd);
            check("rst_reg_read", rd, 32'd0);
        end

        // 1: basic 4x3 fill
        cfg_write(REG_ORIGIN, 32'h0A05);
        cfg_write(REG_SIZE, 32'h0203);
        cfg_write(REG_COLOR, 32'd5);
        cfg_read(REG_ORIGIN, rd);
        check("origin_read", rd, 32'h0A05);
        push_rect(5, 10, 4, 0, 12, 3'd5);
        d0 = done_cnt;
        cfg_write(REG_CTRL, 32'h1);
        check("t1_busy_n1", 32'(busy_o), 32'd1);
        check("t1_we_n1", 32'(vmem_we_o), 32'd0);
        @(negedge clk);
        check("t1_we_n2", 32'(vmem_we_o), 32'd1);
        busy_n = 2;
        wait_done(100, busy_n, got);
        check("t1_done_seen", 32'(got), 32'd1);
        check("t1_fill_cycles", 32'(busy_n), 32'd12);
        @(negedge clk);
        check("t1_done_pulse_width", 32'(done_o), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);
        cfg_read(REG_CTRL, rd);
        check("t1_ctrl_read", rd, 32'h2);

        // 2: CPU steals the port on fill cycles 3 and 4
        cfg_write(REG_CTRL, 32'h2);
        cfg_read(REG_CTRL, rd);
        check("t2_done_cleared", rd, 32'h0);
        push_rect(5, 10, 4, 0, 2, 3'd5);
        push_px(16'h0000, 3'd2);
        push_px(16'h0000, 3'd2);
        push_rect(5, 10, 4, 2, 12, 3'd5);
        d0 = done_cnt;
        cfg_write(REG_CTRL, 32'h1);
        busy_n = 1;
        @(negedge clk); busy_n++;
        @(negedge clk); busy_n++;
        cpu_we = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 3'd2;
        @(negedge clk); busy_n++;
        @(negedge clk); busy_n++;
        cpu_we = 1'b0;
        wait_done(100, busy_n, got);
        check("t2_done_seen", 32'(got), 32'd1);
        check("t2_fill_cycles", 32'(busy_n), 32'd14);
        @(negedge clk);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t2_done_count", 32'(done_cnt - d0), 32'd1);

        // 3: clipping at the bottom-right corner
        cfg_write(REG_ORIGIN, 32'hEEEE);
        cfg_write(REG_SIZE, 32'h0303);
        push_px(16'hEEEE, 3'd5);
        push_px(16'hEEEF, 3'd5);
        push_px(16'hEFEE, 3'd5);
        push_px(16'hEFEF, 3'd5);
        cfg_write(REG_CTRL, 32'h1);
        busy_n = 1;
        wait_done(100, busy_n, got);
        check("t3_done_seen", 32'(got), 32'd1);
        check("t3_fill_cycles", 32'(busy_n), 32'd16);
        @(negedge clk);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: abort a 256x256 fill after pixels x=0..100 of row 0
        cfg_write(REG_ORIGIN, 32'h0000);
        cfg_write(REG_SIZE, 32'hFFFF);
        push_rect(0, 0, 256, 0, 101, 3'd5);
        d0 = done_cnt;
        cfg_write(REG_CTRL, 32'h1);
        repeat (100) @(negedge clk);
        cfg_write(REG_CTRL, 32'h4);
        check("t4_busy_after_abort", 32'(busy_o), 32'd0);
        check("t4_we_after_abort", 32'(vmem_we_o), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        cfg_read(REG_CTRL, rd);
        check("t4_ctrl_read", rd, 32'h0);

        // 5: COLOR write and second start while busy are ignored
        cfg_write(REG_ORIGIN, 32'h0102);
        cfg_write(REG_SIZE, 32'h0202);
        cfg_write(REG_COLOR, 32'd3);
        push_rect(2, 1, 3, 0, 9, 3'd3);
        d0 = done_cnt;
        cfg_write(REG_CTRL, 32'h1);
        cfg_write(REG_COLOR, 32'd7);
        cfg_write(REG_CTRL, 32'h1);
        busy_n = 0;
        wait_done(100, busy_n, got);
        check("t5_done_seen", 32'(got), 32'd1);
        repeat (6) @(negedge clk);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t5_done_count", 32'(done_cnt - d0), 32'd1);
        cfg_read(REG_COLOR, rd);
        check("t5_color_kept", rd, 32'd3);

        // 6: asynchronous reset in the middle of a fill
        cfg_write(REG_ORIGIN, 32'h0000);
        cfg_write(REG_SIZE, 32'h0F0F);
        push_rect(0, 0, 16, 0, 10, 3'd3);
        cfg_write(REG_CTRL, 32'h1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_we_in_reset", 32'(vmem_we_o), 32'd0);
        check("t6_busy_in_reset", 32'(busy_o), 32'd0);
        check("t6_state_in_reset", 32'(dbg_state_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            cfg_read(2'(r), rd);
            check("t6_reg_read", rd, 32'd0);
        end
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t6_we_idle", 32'(vmem_we_o), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
